hamming_seq_ctrl: RTL and testbench

HAMMING_SEQ_CTRL -- requirements
Module: hamming_seq_ctrl

---
 rtl/hamming_seq_ctrl_pkg.sv | 59 +++++
 rtl/hamming_seq_ctrl_if.sv | 29 ++
 rtl/hamming_syn_acc.sv | 37 +++
 rtl/hamming_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_hamming_seq_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_seq_ctrl_pkg.sv
// Purpose: shared definitions for the serial Hamming(10,6) encode/decode controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: codeword/data widths, FSM state encoding, parity/data bit positions,
//           and helpers that place, extract and correct codeword bits.
package hamming_seq_ctrl_pkg;

  localparam int CW_W  = 10;  // codeword width
  localparam int DW    = 6;   // data width
  localparam int SYN_W = 4;   // syndrome / position index width

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_DEC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Parity bit positions (1-based; codeword bit cw[i-1] holds position i)
  localparam logic [SYN_W-1:0] POS_P1 = 4'd1;
  localparam logic [SYN_W-1:0] POS_P2 = 4'd2;
  localparam logic [SYN_W-1:0] POS_P4 = 4'd4;
  localparam logic [SYN_W-1:0] POS_P8 = 4'd8;

  // Data bit d[i] lives at this 1-based codeword position.
  function automatic logic [SYN_W-1:0] data_pos(input logic [2:0] i);
    case (i)
      3'd0:    data_pos = 4'd3;
      3'd1:    data_pos = 4'd5;
      3'd2:    data_pos = 4'd6;
      3'd3:    data_pos = 4'd7;
      3'd4:    data_pos = 4'd9;
      default: data_pos = 4'd10;
    endcase
  endfunction

  // Assemble a codeword from data and the 4 parity bits. Bit k of par is
  // the parity at position 2^k, which is exactly bit k of the XOR of the
  // position indices of every set data bit.
  function automatic logic [CW_W-1:0] build_cw(input logic [DW-1:0] d,
                                               input logic [SYN_W-1:0] par);
    build_cw = {d[5], d[4], par[3], d[3], d[2], d[1], par[2], d[0], par[1], par[0]};
  endfunction

  // Pull the 6 data bits out of positions 3,5,6,7,9,10.
  function automatic logic [DW-1:0] extract_data(input logic [CW_W-1:0] cw);
    extract_data = {cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Flip the bit at 1-based position syn; positions outside 1..10 leave cw as is.
  function automatic logic [CW_W-1:0] correct_cw(input logic [CW_W-1:0] cw,
                                                 input logic [SYN_W-1:0] syn);
    correct_cw = cw;
    for (int i = 0; i < CW_W; i++) begin
      if (syn == SYN_W'(i + 1)) correct_cw[i] = ~cw[i];
    end
  endfunction

endpackage

// File: rtl/hamming_seq_ctrl_if.sv
// Purpose: job-in / result-out valid-ready bundle of the Hamming controller.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready for jobs, out_valid/out_ready for results.
// Ports: master = requester/consumer side, slave = controller side.
interface hamming_seq_ctrl_if;
  import hamming_seq_ctrl_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   mode;       // 0 = encode, 1 = decode
  logic [CW_W-1:0]        in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW_W-1:0]        out_data;
  logic                   err_corr;
  logic                   err_fatal;
  logic [SYN_W-1:0]       syndrome;

  modport master (
    output in_valid, mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_corr, err_fatal, syndrome
  );

  modport slave (
    input  in_valid, mode, in_data, out_ready,
    output in_ready, out_valid, out_data, err_corr, err_fatal, syndrome
  );

endinterface

// File: rtl/hamming_syn_acc.sv
// Purpose: serial XOR accumulator of position indices (parity for encode, syndrome for decode).
// Latency: syn is combinational and already includes the bit offered this cycle.
// Backpressure: none; advances on every cycle enable is high.
// Ports: clk, rst (async high), clear (zero the accumulator), enable, bit_in,
//        index (position of bit_in), syn (running value including this cycle's bit).
module hamming_syn_acc
  import hamming_seq_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  input  logic [SYN_W-1:0] index,
  output logic [SYN_W-1:0] syn
);

  logic [SYN_W-1:0] acc_q;

  // Exposing the look-ahead value lets the controller capture the final
  // result on the same edge that consumes the last bit.
  always_comb begin
    syn = acc_q;
    if (enable && bit_in) syn = acc_q ^ index;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= syn;
    end
  end

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Purpose: bit-serial Hamming(10,6) encoder/decoder with single-error correction and event counters.
// Latency: result valid 6 cycles after acceptance for encode, 10 for decode.
// Backpressure: one job at a time; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (async high); bus (slave: job in, result out with flags/syndrome);
//        corr_cnt/fatal_cnt saturating counters; busy = not IDLE.
module hamming_seq_ctrl
  import hamming_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  hamming_seq_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic [CNT_W-1:0]   fatal_cnt,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [3:0]       bit_cnt;
  logic             mode_r;
  logic [CW_W-1:0]  job_r;

  logic [CW_W-1:0]  res_data;
  logic             res_corr;
  logic             res_fatal;
  logic [SYN_W-1:0] res_syn;

  logic             accept;
  logic             acc_en;
  logic             acc_bit;
  logic [SYN_W-1:0] acc_idx;
  logic [SYN_W-1:0] syn;
  logic             last_bit;

  logic [CW_W-1:0]  res_data_n;
  logic             res_corr_n;
  logic             res_fatal_n;
  logic [SYN_W-1:0] res_syn_n;
  logic [CW_W-1:0]  fixed_cw;

  assign accept = bus.in_valid && bus.in_ready;
  assign acc_en = (state == ST_ENC) || (state == ST_DEC);

  // Feed the accumulator: encode walks data bits and XORs their codeword
  // positions; decode walks codeword positions 1..10 directly.
  always_comb begin
    acc_bit  = 1'b0;
    acc_idx  = '0;
    last_bit = 1'b0;
    case (state)
      ST_ENC: begin
        acc_bit  = job_r[bit_cnt];
        acc_idx  = data_pos(bit_cnt[2:0]);
        last_bit = (bit_cnt == 4'd5);
      end
      ST_DEC: begin
        acc_bit  = job_r[bit_cnt];
        acc_idx  = bit_cnt + 4'd1;
        last_bit = (bit_cnt == 4'd9);
      end
      default: begin
        acc_bit  = 1'b0;
        acc_idx  = '0;
        last_bit = 1'b0;
      end
    endcase
  end

  hamming_syn_acc u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (acc_en),
    .bit_in (acc_bit),
    .index  (acc_idx),
    .syn    (syn)
  );

  // Result as it will look once the current (last) bit is folded in.
  always_comb begin
    res_data_n  = '0;
    res_corr_n  = 1'b0;
    res_fatal_n = 1'b0;
    res_syn_n   = '0;
    fixed_cw    = job_r;
    if (mode_r) begin
      res_syn_n = syn;
      if (syn != 4'd0 && syn <= 4'd10) begin
        res_corr_n = 1'b1;
        fixed_cw   = correct_cw(job_r, syn);
      end else if (syn >= 4'd11) begin
        // Two or more flips alias outside the codeword: report, don't touch.
        res_fatal_n = 1'b1;
      end
      res_data_n = {{(CW_W-DW){1'b0}}, extract_data(fixed_cw)};
    end else begin
      res_data_n = build_cw(job_r[DW-1:0], syn);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      mode_r    <= 1'b0;
      job_r     <= '0;
      res_data  <= '0;
      res_corr  <= 1'b0;
      res_fatal <= 1'b0;
      res_syn   <= '0;
      corr_cnt  <= '0;
      fatal_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_r  <= bus.mode;
            job_r   <= bus.in_data;
            bit_cnt <= '0;
            state   <= bus.mode ? ST_DEC : ST_ENC;
          end
        end
        ST_ENC, ST_DEC: begin
          bit_cnt <= bit_cnt + 4'd1;
          if (last_bit) begin
            state     <= ST_DONE;
            res_data  <= res_data_n;
            res_corr  <= res_corr_n;
            res_fatal <= res_fatal_n;
            res_syn   <= res_syn_n;
            if (res_corr_n && corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + 1'b1;
            if (res_fatal_n && fatal_cnt != CNT_MAX) fatal_cnt <= fatal_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.out_data  = res_data;
  assign bus.err_corr  = res_corr;
  assign bus.err_fatal = res_fatal;
  assign bus.syndrome  = res_syn;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Purpose: directed + randomised self-checking bench for hamming_seq_ctrl (CNT_W=2).
// Latency: expects result 6 cycles (encode) / 10 cycles (decode) after acceptance.
// Backpressure: exercises held results in DONE and in_valid asserted while busy.
module tb_hamming_seq_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] fatal_cnt;
  logic             busy;

  hamming_seq_ctrl_if bus();

  hamming_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .corr_cnt  (corr_cnt),
    .fatal_cnt (fatal_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] data;
    logic       corr;
    logic       fatal;
    logic [3:0] syn;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   exp_corr_cnt  = 0;
  int   exp_fatal_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: written from the position rules, not from the RTL.
  function automatic logic [9:0] ref_encode(input logic [5:0] d);
    int         dpos[6];
    logic [9:0] cw;
    logic       p;
    dpos = '{3, 5, 6, 7, 9, 10};
    cw = '0;
    for (int i = 0; i < 6; i++) cw[dpos[i]-1] = d[i];
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 10; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ cw[pos-1];
      cw[(1 << k) - 1] = p;
    end
    return cw;
  endfunction

  function automatic exp_t ref_decode(input logic [9:0] cw);
    int         dpos[6];
    int         s;
    logic [9:0] c;
    exp_t       e;
    dpos = '{3, 5, 6, 7, 9, 10};
    s = 0;
    for (int pos = 1; pos <= 10; pos++) if (cw[pos-1]) s = s ^ pos;
    c = cw;
    e = '0;
    e.syn = 4'(s);
    if (s >= 1 && s <= 10) begin
      c[s-1] = ~c[s-1];
      e.corr = 1'b1;
    end else if (s >= 11) begin
      e.fatal = 1'b1;
    end
    for (int i = 0; i < 6; i++) e.data[i] = c[dpos[i]-1];
    return e;
  endfunction

  // One complete job; hold > 0 keeps the result un-taken for that many
  // cycles while a new job is offered.
  task automatic run_job(input logic m, input logic [9:0] din, input int hold);
    exp_t       e;
    exp_t       got;
    int         lat;
    logic [9:0] held;
    if (m) e = ref_decode(din);
    else begin
      e = '0;
      e.data = ref_encode(din[5:0]);
    end
    sb.push_back(e);
    if (e.corr && exp_corr_cnt < CNT_MAX) exp_corr_cnt++;
    if (e.fatal && exp_fatal_cnt < CNT_MAX) exp_fatal_cnt++;

    bus.mode     = m;
    bus.in_data  = din;
    bus.in_valid = 1'b1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    tick();
    // Anything on the inputs after acceptance must be ignored.
    bus.in_valid = 1'b0;
    bus.mode     = 1'($urandom);
    bus.in_data  = 10'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);

    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check(m ? "dec_latency" : "enc_latency", 32'(lat), m ? 32'd10 : 32'd6);
    if (bus.out_valid && sb.size() > 0) begin
      got = sb.pop_front();
      check("out_data", 32'(bus.out_data), 32'(got.data));
      check("syndrome", 32'(bus.syndrome), 32'(got.syn));
      check("err_corr", 32'(bus.err_corr), 32'(got.corr));
      check("err_fatal", 32'(bus.err_fatal), 32'(got.fatal));
      check("corr_cnt", 32'(corr_cnt), 32'(exp_corr_cnt));
      check("fatal_cnt", 32'(fatal_cnt), 32'(exp_fatal_cnt));
    end else begin
      sb.delete();
    end

    held = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      tick();
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_data", 32'(bus.out_data), 32'(held));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end

    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    check("busy_after_hs", 32'(busy), 32'd0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] d;
    logic [9:0] cw;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors
    run_job(1'b0, 10'b1111_000001, 0);   // upper bits ignored -> 0000000111
    run_job(1'b1, 10'b0000010111, 0);    // position 5 flipped
    run_job(1'b1, 10'b0100100111, 0);    // positions 6 and 9 flipped -> syndrome 15

    // Random encodes, clean decodes, single-bit-error decodes
    for (int i = 0; i < 4; i++) begin
      d  = 6'($urandom);
      cw = ref_encode(d);
      run_job(1'b0, {4'($urandom), d}, 0);
      run_job(1'b1, cw, 0);
      run_job(1'b1, cw ^ (10'd1 << $urandom_range(0, 9)), 0);
    end

    // Result held in DONE while a new job is offered
    run_job(1'b1, ref_encode(6'h2D) ^ 10'b0000100000, 5);

    // Reset during the third encode cycle
    bus.mode     = 1'b0;
    bus.in_data  = 10'h02A;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    exp_corr_cnt  = 0;
    exp_fatal_cnt = 0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_syndrome", 32'(bus.syndrome), 32'd0);
    check("midrst_flags", 32'({bus.err_corr, bus.err_fatal}), 32'd0);
    check("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("midrst_fatal_cnt", 32'(fatal_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    run_job(1'b0, 10'h015, 0);

    // Saturation of corr_cnt at 2^CNT_W-1
    for (int i = 0; i < 5; i++) begin
      cw = ref_encode(6'($urandom));
      run_job(1'b1, cw ^ (10'd1 << i), 0);
    end
    check("corr_cnt_sat", 32'(corr_cnt), 32'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Watchdog: guarantees termination even if the flow above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
